seed_capture_ctrl: RTL and testbench

- Downstream consumer of the 64-bit LFSR (lfsr64).
- Paces the LFSR, captures a snapshot of shift_seed when the user presses the "randomize" button, and rejects all-zero seeds.
- Delivers the accepted seed to the board/grid loader over a valid/ready handshake.
- Also synchronizes and edge-detects the raw asynchronous button input.

---
 rtl/seed_pkg.sv | 7 +
 rtl/btn_sync_edge.sv | 26 ++
 rtl/seed_capture_ctrl.sv | 123 ++++++++++++
 tb/tb_seed_capture_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared types and constants for the seed capture path that sits behind the 64-bit LFSR.
package seed_pkg;
  typedef enum logic [1:0] {IDLE, MIX, CHECK, PRESENT} cap_state_t;

  localparam int SEED_W = 64;
  localparam logic [SEED_W-1:0] DEFAULT_SEED = 64'hACE1_2468_1357_BDF0;
endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes the raw randomize button and emits a one-cycle pulse per rising edge.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/seed_capture_ctrl.sv
// Paces the LFSR, snapshots a seed on a button press, rejects all-zero seeds
// and hands the accepted seed to the loader over valid/ready.
module seed_capture_ctrl
  import seed_pkg::*;
#(
  parameter int WIDTH       = SEED_W,
  parameter int MIX_CYCLES  = 16,
  parameter int MAX_RETRY   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] shift_seed,
  input  logic             btn_raw,
  output logic             lfsr_en,
  output logic [WIDTH-1:0] seed_out,
  output logic             seed_valid,
  input  logic             seed_ready,
  output logic             busy,
  output logic [7:0]       zero_rejects
);

  localparam logic [7:0] CNT_LOAD  = 8'(MIX_CYCLES - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

  cap_state_t       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [7:0]       zr_q, zr_d;
  logic             btn_edge;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_edge (btn_edge)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    seed_d  = seed_q;
    out_d   = out_q;
    valid_d = valid_q;
    zr_d    = zr_q;
    case (state_q)
      IDLE: begin
        if (btn_edge) begin
          state_d = MIX;
          cnt_d   = CNT_LOAD;
          retry_d = '0;
        end
      end
      MIX: begin
        if (cnt_q == 8'd0) begin
          seed_d  = shift_seed;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CHECK: begin
        if (seed_q != '0) begin
          out_d   = seed_q;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          zr_d = (zr_q == 8'hFF) ? zr_q : zr_q + 8'd1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = CNT_LOAD;
            state_d = MIX;
          end else begin
            // Out of retries: deliver a known-good seed rather than stall the loader.
            seed_d  = WIDTH'(DEFAULT_SEED);
            out_d   = WIDTH'(DEFAULT_SEED);
            valid_d = 1'b1;
            state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (seed_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      seed_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      zr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      seed_q  <= seed_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      zr_q    <= zr_d;
    end
  end

  // Gated by reset so the LFSR is held while the block is in reset.
  assign lfsr_en      = ~reset & ((state_q == IDLE) || (state_q == MIX));
  assign busy         = (state_q != IDLE);
  assign seed_out     = out_q;
  assign seed_valid   = valid_q;
  assign zero_rejects = zr_q;

endmodule

// File: tb/tb_seed_capture_ctrl.sv
// Bench for seed_capture_ctrl: counter-modelled LFSR, randomized press/ready/zero
// patterns, expectations computed from the cycle timing of each transaction.
module tb_seed_capture_ctrl;
  localparam int MIX  = 4;
  localparam int MAXR = 3;
  localparam logic [63:0] DEF_SEED = 64'hACE1_2468_1357_BDF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] shift_seed;
  logic        btn_raw;
  logic        lfsr_en;
  logic [63:0] seed_out;
  logic        seed_valid;
  logic        seed_ready;
  logic        busy;
  logic [7:0]  zero_rejects;

  logic [63:0] lfsr_m;
  logic        zero_now;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] last_seed;
  int          exp_zr;

  seed_capture_ctrl #(.WIDTH(64), .MIX_CYCLES(MIX), .MAX_RETRY(MAXR), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .shift_seed   (shift_seed),
    .btn_raw      (btn_raw),
    .lfsr_en      (lfsr_en),
    .seed_out     (seed_out),
    .seed_valid   (seed_valid),
    .seed_ready   (seed_ready),
    .busy         (busy),
    .zero_rejects (zero_rejects)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LFSR stand-in: a counter from 1 that only advances when enabled.
  always @(posedge clk or posedge reset)
    if (reset) lfsr_m <= 64'd1;
    else if (lfsr_en) lfsr_m <= lfsr_m + 64'd1;

  assign shift_seed = zero_now ? 64'd0 : lfsr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One press-to-handshake transaction. hold: press length, rdy: PRESENT cycles
  // before ready, nz: leading zero captures, glitch: extra presses in MIX and PRESENT.
  task automatic run_txn(input int hold, input int rdy, input int nz, input bit glitch);
    int c0, e, vcyc, done, last, n_rej, zr_after, d, d2;
    bit in_check, in_present, exp_busy;
    logic [63:0] exp_seed;
    c0       = cyc;
    e        = c0 + 2;
    n_rej    = (nz > MAXR) ? MAXR : nz;
    vcyc     = e + MIX + 2 + n_rej * (MIX + 1);
    done     = vcyc + rdy;
    last     = ((done > c0 + hold) ? done : c0 + hold) + 4;
    zr_after = exp_zr + ((nz > MAXR) ? MAXR + 1 : nz);
    if (zr_after > 255) zr_after = 255;
    exp_seed = DEF_SEED;
    for (int t = c0; t <= last; t++) begin
      if (t != c0) @(negedge clk);
      btn_raw    = (t < c0 + hold) || (glitch && (t == c0 + 3 || t == vcyc - 2));
      seed_ready = (t >= vcyc + rdy) || (t < vcyc && $urandom_range(0, 1) == 1);
      d          = t - (e + MIX);
      zero_now   = (d >= 0) && (d % (MIX + 1) == 0) && (d / (MIX + 1) < nz);
      if (nz <= MAXR && t == e + MIX + nz * (MIX + 1)) exp_seed = lfsr_m;
      #1;
      d2         = t - (e + MIX + 1);
      in_check   = (d2 >= 0) && (d2 % (MIX + 1) == 0) && (d2 / (MIX + 1) <= n_rej);
      in_present = (t >= vcyc) && (t <= done);
      exp_busy   = (t >= e + 1) && (t <= done);
      chk("seed_valid", {63'd0, seed_valid}, {63'd0, in_present});
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("lfsr_en", {63'd0, lfsr_en}, {63'd0, !(in_check || in_present)});
      chk("seed_out", seed_out, (t >= vcyc) ? exp_seed : last_seed);
      if (t > done) chk("zero_rejects", {56'd0, zero_rejects}, 64'(zr_after));
    end
    zero_now  = 1'b0;
    last_seed = exp_seed;
    exp_zr    = zr_after;
  endtask

  // Press, advance into MIX or PRESENT, then assert reset between clock edges.
  task automatic reset_mid(input bit in_present);
    int c0, stop;
    c0         = cyc;
    btn_raw    = 1'b1;
    seed_ready = 1'b0;
    stop       = in_present ? c0 + 2 + MIX + 3 : c0 + 4;
    while (cyc < stop) begin
      @(negedge clk);
      btn_raw = 1'b0;
    end
    #1;
    chk("busy_before_reset", {63'd0, busy}, 64'd1);
    chk("valid_before_reset", {63'd0, seed_valid}, {63'd0, in_present});
    #1 reset = 1'b1;
    #1;
    chk("rst_seed_valid", {63'd0, seed_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_lfsr_en", {63'd0, lfsr_en}, 64'd0);
    chk("rst_seed_out", seed_out, 64'd0);
    chk("rst_zero_rejects", {56'd0, zero_rejects}, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    last_seed = 64'd0;
    exp_zr    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", {63'd0, seed_valid}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold, rdy, nz;
    bit gl;
    reset      = 1'b1;
    btn_raw    = 1'b0;
    seed_ready = 1'b0;
    zero_now   = 1'b0;
    last_seed  = 64'd0;
    exp_zr     = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_lfsr_en", {63'd0, lfsr_en}, 64'd0);
    chk("reset_seed_valid", {63'd0, seed_valid}, 64'd0);
    chk("reset_seed_out", seed_out, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_lfsr_en", {63'd0, lfsr_en}, 64'd1);
      chk("idle_seed_valid", {63'd0, seed_valid}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_zero_rejects", {56'd0, zero_rejects}, 64'd0);
    end

    run_txn(5, 0, 0, 1'b0);   // single 5-cycle press, ready already high
    run_txn(3, 20, 0, 1'b0);  // consumer stalls 20 cycles
    run_txn(2, 0, 4, 1'b0);   // every capture zero -> fallback seed
    run_txn(1, 5, 0, 1'b1);   // extra presses in MIX and PRESENT dropped
    run_txn(20, 0, 0, 1'b0);  // press held across return to IDLE
    run_txn(1, 2, 2, 1'b0);   // two rejects then a good seed

    for (int k = 0; k < 10; k++) begin
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 2) == 0) hold = 1;
      rdy  = $urandom_range(0, 6);
      nz   = $urandom_range(0, 4);
      gl   = (hold == 1 && rdy >= 3) ? 1'b1 : 1'b0;
      run_txn(hold, rdy, nz, gl);
    end

    reset_mid(1'b0);
    reset_mid(1'b1);
    run_txn(4, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
